// File: rtl/ram_arbiter.sv
// System RAM port owner: clear engine > HPS loader > CPU, driving a 1-cycle sync RAM.
// Loader path (LOAD/DRAIN, ld_done, ld_err) is built only with `define RAM_ARB_LOAD_EN.
module ram_arbiter #(
  parameter logic [7:0]  CLEAR_VALUE = 8'hFF,
  parameter logic [15:0] LOAD_BASE   = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        clear_req,
  input  logic        cpu_ce,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  input  logic        ld_active,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_dout,
  output logic [15:0] ram_ad,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        hold_cpu,
  output logic        busy,
  output logic        clear_done,
  output logic        ld_done,
  output logic        ld_err
);

  // state | meaning
  // CLEAR | fill RAM with CLEAR_VALUE     IDLE  | CPU owns the port
  // LOAD  | loader bytes go to RAM        DRAIN | last loader write commits
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
`ifdef RAM_ARB_LOAD_EN
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
`endif

  logic [1:0]  r_state;
  logic [16:0] r_clr_cnt;
  logic [15:0] r_ram_ad;
  logic [7:0]  r_ram_d;
  logic [7:0]  r_cpu_q;
  logic        r_ram_we;
  logic        r_clear_done;
  logic        r_rd_p1;
  logic        r_rd_p2;
  logic        w_cpu_acc;

  assign w_cpu_acc = cpu_ce & cpu_cs;

`ifdef RAM_ARB_LOAD_EN
  logic        r_ld_active_d;
  logic        r_ld_pend;
  logic        r_ld_done;
  logic        r_ld_err;
  logic [16:0] w_ld_sum;
  logic        w_ld_rise;

  assign w_ld_sum  = {1'b0, ld_addr} + {1'b0, LOAD_BASE};
  assign w_ld_rise = ld_active & ~r_ld_active_d;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= 17'd0;
      r_ram_ad     <= 16'd0;
      r_ram_d      <= 8'd0;
      r_ram_we     <= 1'b0;
      r_cpu_q      <= 8'd0;
      r_clear_done <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_rd_p2      <= 1'b0;
`ifdef RAM_ARB_LOAD_EN
      r_ld_active_d <= 1'b0;
      r_ld_pend     <= 1'b0;
      r_ld_done     <= 1'b0;
      r_ld_err      <= 1'b0;
`endif
    end else begin
      r_ram_we     <= 1'b0;
      r_clear_done <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_rd_p2      <= r_rd_p1;
      if (r_rd_p2) r_cpu_q <= ram_q;
`ifdef RAM_ARB_LOAD_EN
      r_ld_done     <= 1'b0;
      r_ld_active_d <= ld_active;
      if (w_ld_rise) r_ld_pend <= 1'b1;
      else if (!ld_active) r_ld_pend <= 1'b0;
`endif
      if (clear_req) begin
        r_state   <= S_CLEAR;
        r_clr_cnt <= 17'd0;
        r_rd_p1   <= 1'b0;
        r_rd_p2   <= 1'b0;
`ifdef RAM_ARB_LOAD_EN
        r_ld_err  <= 1'b0;
        r_ld_pend <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (r_clr_cnt[16]) begin
              r_state      <= S_IDLE;
              r_clear_done <= 1'b1;
            end else begin
              r_ram_ad  <= r_clr_cnt[15:0];
              r_ram_d   <= CLEAR_VALUE;
              r_ram_we  <= 1'b1;
              r_clr_cnt <= r_clr_cnt + 17'd1;
            end
          end
          S_IDLE: begin
`ifdef RAM_ARB_LOAD_EN
            // A pending session blocks new CPU slots; enter LOAD once no read is in flight.
            if ((r_ld_pend | w_ld_rise) & ld_active) begin
              if (!r_rd_p1) begin
                r_state   <= S_LOAD;
                r_ld_pend <= 1'b0;
              end
            end else
`endif
            if (w_cpu_acc) begin
              r_ram_ad <= cpu_ad;
              r_ram_d  <= cpu_d;
              r_ram_we <= cpu_we;
              r_rd_p1  <= ~cpu_we;
            end
          end
`ifdef RAM_ARB_LOAD_EN
          // ram_ad/ram_d/ram_we double as the one-deep loader buffer.
          S_LOAD: begin
            if (!ld_active) begin
              r_state <= S_DRAIN;
            end else if (ld_wr) begin
              if (w_ld_sum[16]) begin
                r_ld_err <= 1'b1;
              end else begin
                r_ram_ad <= w_ld_sum[15:0];
                r_ram_d  <= ld_dout;
                r_ram_we <= 1'b1;
              end
            end
          end
          S_DRAIN: begin
            r_state   <= S_IDLE;
            r_ld_done <= 1'b1;
          end
`endif
          default: r_state <= S_CLEAR;
        endcase
      end
    end
  end

  assign ram_ad     = r_ram_ad;
  assign ram_d      = r_ram_d;
  assign ram_we     = r_ram_we;
  assign cpu_q      = r_cpu_q;
  assign clear_done = r_clear_done;
  assign busy       = (r_state != S_IDLE);
  assign hold_cpu   = (r_state != S_IDLE);

`ifdef RAM_ARB_LOAD_EN
  assign ld_done = r_ld_done;
  assign ld_err  = r_ld_err;
`else
  logic w_unused_ld;
  assign w_unused_ld = &{1'b0, ld_active, ld_wr, ld_addr, ld_dout, LOAD_BASE};
  assign ld_done = 1'b0;
  assign ld_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM plus a reference memory image.
module tb_ram_arbiter;
  localparam logic [15:0] BASE = 16'h0500;

  logic        clk_sys = 1'b0;
  logic        reset_n, clear_req, cpu_ce, cpu_cs, cpu_we;
  logic [15:0] cpu_ad, ld_addr;
  logic [7:0]  cpu_d, ld_dout;
  logic        ld_active, ld_wr;
  logic [7:0]  cpu_q, ram_d, ram_q;
  logic [15:0] ram_ad;
  logic        ram_we, hold_cpu, busy, clear_done, ld_done, ld_err;

  ram_arbiter #(.CLEAR_VALUE(8'hFF), .LOAD_BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .clear_req(clear_req),
    .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ad(cpu_ad),
    .cpu_d(cpu_d), .cpu_q(cpu_q), .ld_active(ld_active), .ld_wr(ld_wr),
    .ld_addr(ld_addr), .ld_dout(ld_dout), .ram_ad(ram_ad), .ram_d(ram_d),
    .ram_we(ram_we), .ram_q(ram_q), .hold_cpu(hold_cpu), .busy(busy),
    .clear_done(clear_done), .ld_done(ld_done), .ld_err(ld_err));

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram [0:65535];
  always @(posedge clk_sys) begin
    if (ram_we) ram[ram_ad] <= ram_d;
    ram_q <= ram[ram_ad];
  end

  logic [7:0] ref_mem [0:65535];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Runs clear cycles while poking junk CPU/loader strobes that must be ignored.
  task automatic run_clear(input int budget, output int nw, output int bad, output int done_at);
    nw = 0; bad = 0; done_at = -1;
    for (int c = 1; c <= budget; c++) begin
      cpu_ce = (c % 7 == 0); cpu_cs = 1'b1; cpu_we = 1'b1;
      cpu_ad = 16'($urandom); cpu_d = 8'h00;
      ld_wr = (c % 5 == 0); ld_addr = 16'($urandom); ld_dout = 8'h00;
      step();
      if (ram_we) begin
        if (ram_ad !== nw[15:0] || ram_d !== 8'hFF) bad++;
        nw++;
      end
      if (clear_done) begin done_at = c; break; end
    end
    cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; ld_wr = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] ad, input logic [7:0] d);
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = we; cpu_ad = ad; cpu_d = d;
    step();
    cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    chk("cpu_ram_we", 32'(ram_we), 32'(we));
    chk("cpu_ram_ad", 32'(ram_ad), 32'(ad));
    if (we) begin
      chk("cpu_ram_d", 32'(ram_d), 32'(d));
      ref_mem[ad] = d;
      step();
      chk("cpu_we_one_cycle", 32'(ram_we), 32'd0);
      step(); step();
    end else begin
      step(); step();
      chk("cpu_read_q", 32'(cpu_q), 32'(ref_mem[ad]));
      step();
    end
  endtask

`ifdef RAM_ARB_LOAD_EN
  task automatic start_session(output logic entered);
    ld_active = 1'b1;
    entered = 1'b0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (hold_cpu === 1'b1) begin entered = 1'b1; break; end
    end
  endtask

  task automatic end_session(output int ndone, output logic hold_at_done);
    ld_active = 1'b0; ld_wr = 1'b0;
    ndone = 0; hold_at_done = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ld_done) begin ndone++; hold_at_done = hold_cpu; end
    end
  endtask
`endif

  int nw, bad, done_at, nd;
  logic ok, hold_d;
  logic [15:0] a;
  logic [7:0] d, last_rd, d99;

  initial begin
    reset_n = 1'b0; clear_req = 1'b0; cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    cpu_ad = 16'd0; cpu_d = 8'd0; ld_active = 1'b0; ld_wr = 1'b0;
    ld_addr = 16'd0; ld_dout = 8'd0;
    repeat (3) step();
    chk("rst_outputs", {ram_we, ram_d, ram_ad, cpu_q}, 32'd0);
    chk("rst_flags", {hold_cpu, busy, clear_done, ld_done, ld_err}, 32'b11000);

    // Partial clear, then reset mid-fill: must restart from address 0.
    reset_n = 1'b1;
    run_clear(256, nw, bad, done_at);
    chk("partial_clear_writes", nw, 256);
    chk("partial_clear_bad", bad, 0);
    reset_n = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin step(); if (ram_we !== 1'b0) bad++; end
    chk("reset_no_we", bad, 0);
    chk("reset_busy", {busy, hold_cpu}, 2'b11);

    reset_n = 1'b1;
    run_clear(70000, nw, bad, done_at);
    chk("clear_write_count", nw, 65536);
    chk("clear_write_bad", bad, 0);
    chk("clear_done_cycle", done_at, 65537);
    chk("clear_hold_drop", {hold_cpu, busy}, 2'b00);
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'hFF;
    step();
    chk("clear_done_pulse", clear_done, 1'b0);

    cpu_access(1'b1, 16'h1234, 8'h5A);
    cpu_access(1'b0, 16'h1234, 8'h00);
    chk("cpu_read_5a", cpu_q, 8'h5A);
    last_rd = 8'h5A;
    cpu_access(1'b1, 16'h0042, 8'hC3);
    chk("cpu_q_held", cpu_q, last_rd);
    cpu_ce = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b1; cpu_ad = 16'h1234; cpu_d = 8'h00;
    step();
    cpu_ce = 1'b0; cpu_we = 1'b0;
    chk("cpu_cs_low_no_we", ram_we, 1'b0);
    repeat (3) step();
    for (int k = 0; k < 24; k++) begin
      a = 16'h4000 + 16'($urandom_range(0, 7));
      d = 8'($urandom);
      cpu_access(1'($urandom_range(0, 1)), a, d);
    end
    cpu_access(1'b0, 16'h1234, 8'h00);

`ifdef RAM_ARB_LOAD_EN
    start_session(ok);
    chk("load_entry", ok, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      ld_wr = 1'b1; ld_addr = 16'(i); ld_dout = d;
      ref_mem[BASE + 16'(i)] = d;
      step();
      if (ram_we !== 1'b1 || ram_ad !== BASE + 16'(i) || ram_d !== d) bad++;
    end
    ld_wr = 1'b0;
    chk("stream_we_timing", bad, 0);
    end_session(nd, hold_d);
    chk("stream_ld_done_once", nd, 1);
    chk("stream_hold_at_done", hold_d, 1'b0);
    chk("stream_ld_err", ld_err, 1'b0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[BASE + 16'(i)] !== ref_mem[BASE + 16'(i)]) bad++;
    chk("stream_ram_image", bad, 0);
    for (int k = 0; k < 6; k++) cpu_access(1'b0, BASE + 16'($urandom_range(0, 255)), 8'h00);

    // Read in flight when the session opens: read finishes before LOAD.
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_ad = BASE + 16'h0010;
    step();
    cpu_ce = 1'b0; cpu_cs = 1'b0; ld_active = 1'b1;
    step(); step();
    chk("defer_read_q", cpu_q, ref_mem[BASE + 16'h0010]);
    start_session(ok);
    chk("defer_load_entry", ok, 1'b1);
    ld_wr = 1'b1; ld_addr = 16'hFAFF; ld_dout = 8'h77;
    ref_mem[16'hFFFF] = 8'h77;
    step();
    chk("edge_addr_ffff", {ram_we, ram_ad, ram_d}, {1'b1, 16'hFFFF, 8'h77});
    ld_addr = 16'hFB00; ld_dout = 8'h99;
    step();
    ld_wr = 1'b0;
    chk("overflow_no_we", ram_we, 1'b0);
    chk("overflow_err", ld_err, 1'b1);
    end_session(nd, hold_d);
    chk("overflow_ld_done", nd, 1);
    chk("overflow_err_sticky", ld_err, 1'b1);
    cpu_access(1'b0, 16'hFFFF, 8'h00);
    cpu_access(1'b0, 16'h0000, 8'h00);

    // clear_req coinciding with loader byte 100 discards it.
    start_session(ok);
    chk("cr_load_entry", ok, 1'b1);
    for (int i = 0; i < 100; i++) begin
      ld_wr = 1'b1; ld_addr = 16'h0200 + 16'(i); ld_dout = 8'($urandom); d99 = ld_dout;
      step();
    end
    ld_addr = 16'h0264; ld_dout = 8'h3C; ld_wr = 1'b1; clear_req = 1'b1;
    step();
    clear_req = 1'b0; ld_wr = 1'b0;
    chk("cr_no_write", ram_we, 1'b0);
    chk("cr_err_cleared", ld_err, 1'b0);
    chk("cr_hold", {hold_cpu, busy}, 2'b11);
    run_clear(1000, nw, bad, done_at);
    chk("cr_restart_writes", nw, 1000);
    chk("cr_restart_bad", bad, 0);
    chk("cr_not_done", done_at, -1);
    chk("cr_byte100_dropped", ram[16'h0764], 8'hFF);
    chk("cr_byte99_written", ram[16'h0763], d99);
    ld_active = 1'b0;
`else
    ld_active = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ld_wr = 1'b1; ld_addr = 16'(i); ld_dout = 8'($urandom);
      step();
      if (ram_we !== 1'b0 || hold_cpu !== 1'b0) bad++;
    end
    ld_wr = 1'b0; ld_active = 1'b0;
    step();
    chk("noload_ignored", bad, 0);
    chk("noload_flags", {ld_done, ld_err}, 2'b00);
    cpu_access(1'b0, 16'h0005, 8'h00);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("cr_no_write", ram_we, 1'b0);
    chk("cr_hold", {hold_cpu, busy}, 2'b11);
    run_clear(1000, nw, bad, done_at);
    chk("cr_restart_writes", nw, 1000);
    chk("cr_restart_bad", bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
